// File: rtl/wb_ram_slave_if.sv
// Wishbone B4 classic bus bundle for wb_ram_slave. Signal names keep their
// original _in/_out suffixes (seen from the slave) so existing hookups still match.
interface wb_ram_slave_if;
  logic        wb_cyc_in;
  logic        wb_stb_in;
  logic        wb_we_in;
  logic [31:0] wb_adr_in;
  logic [31:0] wb_dat_in;
  logic [3:0]  wb_sel_in;
  logic [31:0] wb_dat_out;
  logic        wb_ack_out;
  logic        wb_err_out;

  modport master (
    output wb_cyc_in, wb_stb_in, wb_we_in, wb_adr_in, wb_dat_in, wb_sel_in,
    input  wb_dat_out, wb_ack_out, wb_err_out
  );

  modport slave (
    input  wb_cyc_in, wb_stb_in, wb_we_in, wb_adr_in, wb_dat_in, wb_sel_in,
    output wb_dat_out, wb_ack_out, wb_err_out
  );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic slave around a byte-writable word RAM, with programmable
// wait states. Define WB_RAM_SLAVE_ERR_EN to terminate out-of-range accesses with err.
module wb_ram_slave #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic           clk_in,
  input  logic           reset_in,
  wb_ram_slave_if.slave  bus
);

  localparam int unsigned AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       capture;
  logic       enter_resp;

  logic [31:0] mem [MEM_WORDS];

  // Decode of the live bus request.
  logic          req;
  logic [32:0]   off_in;
  logic          inr_in;
  logic [AW-1:0] idx_in;

  assign req    = bus.wb_cyc_in & bus.wb_stb_in;
  assign off_in = {1'b0, bus.wb_adr_in} - {1'b0, BASE_ADDR};
  assign inr_in = (off_in < SPAN);
  assign idx_in = off_in[AW+1:2];

  logic          we_q;
  logic          inr_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;

  // With zero wait states the RESP edge is the request edge itself, so the
  // operation must come straight off the bus instead of from the latches.
  logic          op_we;
  logic          op_inr;
  logic [AW-1:0] op_idx;
  logic [31:0]   op_dat;
  logic [3:0]    op_sel;
  logic          op_err;
  logic          mem_wr;

  always_comb begin
    if (state_q == IDLE) begin
      op_we  = bus.wb_we_in;
      op_inr = inr_in;
      op_idx = idx_in;
      op_dat = bus.wb_dat_in;
      op_sel = bus.wb_sel_in;
    end else begin
      op_we  = we_q;
      op_inr = inr_q;
      op_idx = idx_q;
      op_dat = dat_q;
      op_sel = sel_q;
    end
  end

`ifdef WB_RAM_SLAVE_ERR_EN
  assign op_err = ~op_inr;
`else
  assign op_err = 1'b0;
`endif

  assign mem_wr = enter_resp & op_we & op_inr & reset_in;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          cnt_d   = WS;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!bus.wb_cyc_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic        ack_q;
  logic [31:0] dat_out_q;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      we_q      <= 1'b0;
      inr_q     <= 1'b0;
      idx_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      ack_q     <= 1'b0;
      dat_out_q <= '0;
    end else begin
      if (capture) begin
        we_q  <= bus.wb_we_in;
        inr_q <= inr_in;
        idx_q <= idx_in;
        dat_q <= bus.wb_dat_in;
        sel_q <= bus.wb_sel_in;
      end
      ack_q <= enter_resp & ~op_err;
      if (enter_resp && !op_we) begin
        dat_out_q <= op_inr ? mem[op_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (mem_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (op_sel[i]) mem[op_idx][8*i +: 8] <= op_dat[8*i +: 8];
      end
    end
  end

`ifdef WB_RAM_SLAVE_ERR_EN
  logic err_q;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) err_q <= 1'b0;
    else           err_q <= enter_resp & op_err;
  end

  assign bus.wb_err_out = err_q;
`else
  assign bus.wb_err_out = 1'b0;
`endif

  assign bus.wb_ack_out = ack_q;
  assign bus.wb_dat_out = dat_out_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: four instances (0/1/3/5 wait states) share one stimulus
// bus, selected by dsel, and are checked against a word-array model of the RAM.
module tb_wb_ram_slave;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  dsel = 2'd0;
  logic        cyc  = 1'b0;
  logic        stb  = 1'b0;
  logic        we   = 1'b0;
  logic [31:0] adr  = '0;
  logic [31:0] dat  = '0;
  logic [3:0]  sel  = '0;

  logic [3:0]  ack_v, err_v;
  logic [31:0] dat_v [4];
  logic        ack_o, err_o;
  logic [31:0] dat_o;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_dut
    wb_ram_slave_if bus ();
    assign bus.wb_cyc_in = cyc && (dsel == 2'(g));
    assign bus.wb_stb_in = stb && (dsel == 2'(g));
    assign bus.wb_we_in  = we;
    assign bus.wb_adr_in = adr;
    assign bus.wb_dat_in = dat;
    assign bus.wb_sel_in = sel;
    assign ack_v[g] = bus.wb_ack_out;
    assign err_v[g] = bus.wb_err_out;
    assign dat_v[g] = bus.wb_dat_out;
    wb_ram_slave #(
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 5)
    ) u_dut (
      .clk_in  (clk),
      .reset_in(rst_n),
      .bus     (bus)
    );
  end

  assign ack_o = ack_v[dsel];
  assign err_o = err_v[dsel];
  assign dat_o = dat_v[dsel];

`ifdef WB_RAM_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ws_tab [4] = '{0, 1, 3, 5};
  logic [31:0] mdl [4][16];
  logic [31:0] last_rd [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at a falling edge; return at the falling edge where a
  // termination is seen (lat = cycles after the request edge, 0 on timeout).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat,
                      output logic got_ack, output logic got_err);
    we = w; adr = a; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    lat = 0; got_ack = 1'b0; got_err = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ack_o || err_o) begin
        lat = c; got_ack = ack_o; got_err = err_o;
        break;
      end
    end
    rd  = dat_o;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd, exp, wd;
    int          lat, k;
    logic        ga, ge, inr, exp_err;
    k = int'(dsel);
    xfer(w, a, d, s, rd, lat, ga, ge);
    inr     = (a < 32'h1000);
    exp_err = ERR_EN && !inr;
    chk({tag, "_lat"}, 32'(lat), 32'(ws_tab[k] + 1));
    chk({tag, "_ack"}, {31'b0, ga}, {31'b0, !exp_err});
    chk({tag, "_err"}, {31'b0, ge}, {31'b0, exp_err});
    if (!w) begin
      exp = inr ? mdl[k][a[5:2]] : 32'h0;
      chk({tag, "_rdata"}, rd, exp);
      last_rd[k] = exp;
    end else begin
      chk({tag, "_hold"}, rd, last_rd[k]);
      if (inr) begin
        wd = mdl[k][a[5:2]];
        for (int b = 0; b < 4; b++) if (s[b]) wd[8*b +: 8] = d[8*b +: 8];
        mdl[k][a[5:2]] = wd;
      end
    end
    @(negedge clk);
    chk({tag, "_pulse"}, {30'b0, ack_o, err_o}, 32'h0);
  endtask

  // Continuous reads with stb held through RESP: acks are expected at
  // cycle ws+1 and every ws+2 cycles after that.
  task automatic burst();
    int k, ws, len, nack, nbad;
    logic expa;
    k = int'(dsel); ws = ws_tab[k]; len = 4 * (ws + 2); nack = 0; nbad = 0;
    we = 1'b0; adr = 32'h10 | 32'($urandom_range(0, 3)); sel = 4'h3; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      expa = (c >= ws + 1) && (((c - ws - 1) % (ws + 2)) == 0);
      if (ack_o !== expa) nbad++;
      if (ack_o === 1'b1) begin
        nack++;
        if (dat_o !== mdl[k][4]) nbad++;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    last_rd[k] = mdl[k][4];
    chk("b2b_count", 32'(nack), 32'd4);
    chk("b2b_pattern", 32'(nbad), 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int stray;
    stray = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (ack_o !== 1'b0 || err_o !== 1'b0) stray++;
    end
    chk(tag, 32'(stray), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      dsel = 2'(k);
      #1;
      chk("rst_ack", {31'b0, ack_o}, 32'h0);
      chk("rst_err", {31'b0, err_o}, 32'h0);
      chk("rst_dat", dat_o, 32'h0);
      last_rd[k] = 32'h0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      dsel = 2'(k);
      for (int i = 0; i < 16; i++) txn("init", 1'b1, 32'(i * 4), $urandom, 4'hF);

      txn("wr_dead", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      txn("rd_dead", 1'b0, 32'h10, 32'h0, 4'hF);
      chk("dead_value", last_rd[k], 32'hDEADBEEF);

      txn("wr_lanes", 1'b1, 32'h10, 32'h11223344, 4'b0101);
      txn("rd_lanes", 1'b0, 32'h13, 32'h0, 4'h1);
      chk("lanes_value", last_rd[k], 32'hDE22BE44);
      txn("wr_sel0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
      txn("rd_sel0", 1'b0, 32'h10, 32'h0, 4'hF);
      chk("sel0_value", last_rd[k], 32'hDE22BE44);

      burst();

      txn("rd_w0_pre", 1'b0, 32'h0, 32'h0, 4'hF);
      txn("wr_oor", 1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF);
      txn("rd_oor", 1'b0, 32'h1000, 32'h0, 4'hF);
      txn("rd_w0", 1'b0, 32'h0, 32'h0, 4'hF);

      if (ws_tab[k] > 0) begin
        we = 1'b1; adr = 32'h20; dat = ~mdl[k][8]; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_mid", {30'b0, ack_o, err_o}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        quiet("abort_quiet", ws_tab[k] + 4);
        txn("abort_rd", 1'b0, 32'h20, 32'h0, 4'hF);
      end

      for (int i = 0; i < 24; i++) begin
        case ($urandom_range(0, 7))
          0:       a = 32'h1000;
          1:       a = 32'hFFFF_FFFC;
          2:       a = 32'h8000_0004;
          default: a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        endcase
        s = 4'($urandom_range(0, 15));
        txn("rand", 1'($urandom_range(0, 1)), a, $urandom, s);
      end
    end

    // Asynchronous reset while the 3-wait-state instance sits in WAIT.
    dsel = 2'd2;
    txn("pre_rst_rd", 1'b0, 32'h10, 32'h0, 4'hF);
    we = 1'b1; adr = 32'h10; dat = 32'h55555555; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ack", {31'b0, ack_o}, 32'h0);
    chk("midrst_err", {31'b0, err_o}, 32'h0);
    chk("midrst_dat", dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) last_rd[k] = 32'h0;
    quiet("postrst_quiet", 8);
    txn("postrst_rd", 1'b0, 32'h10, 32'h0, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
